instruction_fetch_unit: RTL and testbench

Front end of the single-cycle MIPS datapath: holds the program counter and an on-chip instruction memory, presents the current instruction word and its 6-bit opcode to the main control decoder, and consumes the decoder's 2-bit branch code plus the ALU zero flag to select the next PC. A load port fills instruction memory while the core is idle. A run/halt state machine gates execution.

---
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch front end: PC, instruction memory and branch/next-PC selection.
// A run/halt FSM gates execution; memory is loadable while idle.
module instruction_fetch_unit #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         LoadEn,
  input  logic [$clog2(MEM_DEPTH)-1:0] LoadAddr,
  input  logic [31:0]                  LoadData,
  input  logic                         Run,
  input  logic [1:0]                   Branch,
  input  logic                         Zero,
  output logic [31:0]                  Instruction,
  output logic [5:0]                   Opcode,
  output logic [31:0]                  PC,
  output logic [31:0]                  PCPlus4,
  output logic                         Valid,
  output logic                         Halted,
  output logic [31:0]                  FetchCount
);

  localparam int          AW  = $clog2(MEM_DEPTH);
  localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        mem_we;
  logic [31:0] mem [MEM_DEPTH];

  logic          running;
  logic          oob;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic          halt_cond;
  logic          taken;
  logic [31:0]   offset;
  logic [31:0]   target;

  assign running = (state == RUN);
  assign idx     = pc[AW+1:2];
  assign word    = mem[idx];
  // Word address is widened so MEM_DEPTH = 2^30 still compares correctly.
  assign oob     = {1'b0, pc[31:2]} >= 31'(MEM_DEPTH);

  assign Instruction = (running && !oob) ? word : '0;
  assign Opcode      = Instruction[31:26];
  assign PC          = pc;
  assign PCPlus4     = pc + 32'd4;
  assign Valid       = running;
  assign Halted      = (state == HALT);
  assign FetchCount  = count;

  assign halt_cond = running && (oob || (Instruction == 32'hFFFF_FFFF));
  assign taken     = Branch[0] & (Branch[1] ? Zero : ~Zero);
  assign offset    = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
  assign target    = PCPlus4 + offset;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = count;
    mem_we     = 1'b0;
    unique case (state)
      IDLE: begin
        mem_we = LoadEn;
        if (Run) state_next = RUN;
      end
      RUN: begin
        if (halt_cond) begin
          state_next = HALT;
        end else if (!Run) begin
          state_next = IDLE;
        end else begin
          pc_next    = taken ? target : PCPlus4;
          count_next = count + 32'd1;
        end
      end
      HALT: ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= PC0;
      count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
    end
  end

  // Program storage survives Reset.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) mem[LoadAddr] <= LoadData;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two depths driven together,
// checked each cycle against a behavioural model plus literal pins.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        LoadEn = 1'b0;
  logic [7:0]  LoadAddr = '0;
  logic [31:0] LoadData = '0;
  logic        Run = 1'b0;
  logic [1:0]  Branch = '0;
  logic        Zero = 1'b0;

  logic [31:0] b_ins, b_pc, b_p4, b_cnt;
  logic [5:0]  b_op;
  logic        b_valid, b_halted;
  logic [31:0] s_ins, s_pc, s_p4, s_cnt;
  logic [5:0]  s_op;
  logic        s_valid, s_halted;
  logic        s_load_en;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam logic [31:0] W0 = 32'h1420_0003;
  localparam logic [31:0] W1 = 32'h2002_0001;
  localparam logic [31:0] W2 = 32'h1000_FFFE;
  localparam logic [31:0] W3 = 32'h0000_0020;
  localparam logic [31:0] W4 = 32'h2003_0007;

  always #5 Clock = ~Clock;

  assign s_load_en = LoadEn && (LoadAddr < 8'd4);

  instruction_fetch_unit #(.MEM_DEPTH(256)) u_big (
    .Clock(Clock), .Reset(Reset),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .Run(Run),
    .Branch(Branch), .Zero(Zero),
    .Instruction(b_ins), .Opcode(b_op),
    .PC(b_pc), .PCPlus4(b_p4),
    .Valid(b_valid), .Halted(b_halted),
    .FetchCount(b_cnt)
  );

  instruction_fetch_unit #(.MEM_DEPTH(4)) u_small (
    .Clock(Clock), .Reset(Reset),
    .LoadEn(s_load_en), .LoadAddr(LoadAddr[1:0]),
    .LoadData(LoadData), .Run(Run),
    .Branch(Branch), .Zero(Zero),
    .Instruction(s_ins), .Opcode(s_op),
    .PC(s_pc), .PCPlus4(s_p4),
    .Valid(s_valid), .Halted(s_halted),
    .FetchCount(s_cnt)
  );

  // Model: state 0 idle, 1 run, 2 halt.
  int          dep [2] = '{256, 4};
  logic [31:0] mm [2][256];
  int          mst [2];
  logic [31:0] mpc [2];
  logic [31:0] mcnt [2];

  function automatic logic [31:0] exp_ins(int k);
    if (mst[k] == 1 && (mpc[k] >> 2) < dep[k])
      return mm[k][mpc[k] >> 2];
    return 32'h0;
  endfunction

  always @(posedge Clock) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ins;
      int          off;
      bit          tk;
      ins = exp_ins(k);
      if (Reset) begin
        mst[k] = 0; mpc[k] = 0; mcnt[k] = 0;
      end else if (mst[k] == 0) begin
        if (LoadEn && LoadAddr < dep[k])
          mm[k][LoadAddr] = LoadData;
        if (Run) mst[k] = 1;
      end else if (mst[k] == 1) begin
        if ((mpc[k] >> 2) >= dep[k] || ins == 32'hFFFF_FFFF) begin
          mst[k] = 2;
        end else if (!Run) begin
          mst[k] = 0;
        end else begin
          tk = (Branch == 2'b11 && Zero) ||
               (Branch == 2'b01 && !Zero);
          off = int'($signed(ins[15:0])) * 4;
          mpc[k] = mpc[k] + 32'd4 + (tk ? off : 0);
          mcnt[k] = mcnt[k] + 1;
        end
      end
    end
  end

  task automatic check(input string n,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, want %h",
               n, $time, act, exp);
    end
  endtask

  task automatic cmp(input string n, input int k,
                     input logic [31:0] ins,
                     input logic [5:0]  op,
                     input logic [31:0] pc,
                     input logic [31:0] p4,
                     input logic        v,
                     input logic        h,
                     input logic [31:0] cnt);
    logic [31:0] e;
    e = exp_ins(k);
    check({n, ".ins"}, ins, e);
    check({n, ".op"}, {26'b0, op}, {26'b0, e[31:26]});
    check({n, ".pc"}, pc, mpc[k]);
    check({n, ".pc4"}, p4, mpc[k] + 32'd4);
    check({n, ".valid"}, {31'b0, v}, {31'b0, mst[k] == 1});
    check({n, ".halted"}, {31'b0, h}, {31'b0, mst[k] == 2});
    check({n, ".cnt"}, cnt, mcnt[k]);
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      cmp("big", 0, b_ins, b_op, b_pc, b_p4,
          b_valid, b_halted, b_cnt);
      cmp("small", 1, s_ins, s_op, s_pc, s_p4,
          s_valid, s_halted, s_cnt);
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1; Run = 1'b0;
    Branch = 2'b00; Zero = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] a,
                      input logic [31:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_pc", b_pc, 32'h0);
    check("rst_valid", {31'b0, b_valid}, 32'h0);
    check("rst_halted", {31'b0, b_halted}, 32'h0);
    check("rst_cnt", b_cnt, 32'h0);
    check("rst_ins", b_ins, 32'h0);

    // Straight-line fetch
    load(8'd0, W0); load(8'd1, W1); load(8'd2, W2);
    load(8'd3, W3); load(8'd4, W4);
    Run = 1'b1;
    tick();
    check("seq_ins0", b_ins, W0);
    check("seq_op0", {26'b0, b_op}, 32'h5);
    tick(); tick();
    check("seq_op2", {26'b0, b_op}, 32'h4);
    tick();
    check("seq_pc12", b_pc, 32'd12);
    check("seq_cnt3", b_cnt, 32'd3);
    Run = 1'b0;
    tick();
    check("pause_pc", b_pc, 32'd12);

    // BEQ at PC=8
    do_reset();
    Run = 1'b1;
    tick(); tick(); tick();
    Branch = 2'b11; Zero = 1'b1;
    tick();
    check("beq_taken", b_pc, 32'd4);
    Branch = 2'b00;
    tick();
    Branch = 2'b11; Zero = 1'b0;
    tick();
    check("beq_not", b_pc, 32'd12);
    Branch = 2'b00; Run = 1'b0;
    tick();

    // BNE at PC=0; small depth runs off the end
    do_reset();
    Run = 1'b1;
    tick();
    Branch = 2'b01; Zero = 1'b0;
    tick();
    check("bne_taken", b_pc, 32'd16);
    check("bne_ins16", b_ins, W4);
    check("oob_ins", s_ins, 32'h0);
    Run = 1'b0; Branch = 2'b00;
    tick();
    check("oob_halt", {31'b0, s_halted}, 32'h1);
    check("oob_pc", s_pc, 32'd16);
    check("oob_cnt", s_cnt, 32'd1);
    do_reset();
    Run = 1'b1;
    tick();
    Branch = 2'b01; Zero = 1'b1;
    tick();
    check("bne_zero", b_pc, 32'd4);
    do_reset();
    Run = 1'b1;
    tick();
    Branch = 2'b10; Zero = 1'b0;
    tick();
    check("br10", b_pc, 32'd4);

    // Halt word at PC=12
    do_reset();
    load(8'd3, 32'hFFFF_FFFF);
    Run = 1'b1;
    tick(); tick(); tick(); tick();
    check("hw_ins", b_ins, 32'hFFFF_FFFF);
    tick();
    check("hw_halt", {31'b0, b_halted}, 32'h1);
    check("hw_pc", b_pc, 32'd12);
    check("hw_cnt", b_cnt, 32'd3);
    LoadEn = 1'b1; LoadAddr = 8'd0;
    LoadData = 32'hDEAD_BEEF;
    tick();
    LoadEn = 1'b0;
    do_reset();
    check("hw_rst_pc", b_pc, 32'h0);
    Run = 1'b1;
    tick();
    check("prog_kept", b_ins, W0);

    // Pause and resume at PC=8
    do_reset();
    load(8'd3, W3);
    Run = 1'b1;
    tick(); tick(); tick();
    Run = 1'b0;
    tick();
    check("hold_pc", b_pc, 32'd8);
    check("hold_valid", {31'b0, b_valid}, 32'h0);
    Run = 1'b1;
    tick();
    check("resume_pc", b_pc, 32'd8);
    check("resume_cnt", b_cnt, 32'd2);
    tick(); tick();
    check("end_pc", s_pc, 32'd16);
    check("end_ins", s_ins, 32'h0);
    tick();
    check("end_halt", {31'b0, s_halted}, 32'h1);

    // Load and run on the same edge, then reset mid-run
    do_reset();
    LoadEn = 1'b1; LoadAddr = 8'd0;
    LoadData = 32'h0000_0020; Run = 1'b1;
    tick();
    LoadEn = 1'b0;
    check("ldrun_big", b_ins, 32'h0000_0020);
    check("ldrun_small", s_ins, 32'h0000_0020);
    tick();
    Reset = 1'b1;
    tick();
    check("rrun_valid", {31'b0, b_valid}, 32'h0);
    check("rrun_pc", b_pc, 32'h0);
    check("rrun_cnt", b_cnt, 32'h0);
    Reset = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
